regwb: RTL



---
 rtl/regwb_pkg.sv | 31 +++
 rtl/regwb_if.sv | 44 ++++
 rtl/regwb_fifo.sv | 92 +++++++++
 rtl/regwb.sv | 106 ++++++++++
 4 files changed

// File: rtl/regwb_pkg.sv
// ============================================================================
// Module      : regwb_pkg
// Description : Shared constants and types for the register-file writeback
//               arbiter (regwb) and its slow-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regwb_pkg;

    localparam int              REG_W    = 5;
    localparam int              DATA_W   = 32;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    // One register-file write: destination register and data.
    // ("reg" is a keyword, so the destination field is named rd.)
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // One queue slot. A dead entry still occupies a slot until it reaches
    // the head and is discarded.
    typedef struct packed {
        logic    live;
        wb_req_t req;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/regwb_if.sv
// ============================================================================
// Module      : regwb_if
// Description : Bus bundle between the result producers (master side) and the
//               writeback arbiter (slave side).
//   pipe_valid/pipe_reg/pipe_data : main pipeline write request
//   slow_valid/slow_ready/slow_reg/slow_data : slow-unit handshake
//   regwrite/wrreg/wrdata         : register-file write port (registered)
//   pend_mask                     : per-register pending-write scoreboard
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regwb_if;
    import regwb_pkg::*;

    logic                pipe_valid;
    logic [REG_W-1:0]    pipe_reg;
    logic [DATA_W-1:0]   pipe_data;
    logic                slow_valid;
    logic                slow_ready;
    logic [REG_W-1:0]    slow_reg;
    logic [DATA_W-1:0]   slow_data;
    logic                regwrite;
    logic [REG_W-1:0]    wrreg;
    logic [DATA_W-1:0]   wrdata;
    logic [31:0]         pend_mask;

    modport master (
        output pipe_valid, pipe_reg, pipe_data,
        output slow_valid, slow_reg, slow_data,
        input  slow_ready,
        input  regwrite, wrreg, wrdata, pend_mask
    );

    modport slave (
        input  pipe_valid, pipe_reg, pipe_data,
        input  slow_valid, slow_reg, slow_data,
        output slow_ready,
        output regwrite, wrreg, wrdata, pend_mask
    );

endinterface

`default_nettype wire

// File: rtl/regwb_fifo.sv
// ============================================================================
// Module      : regwb_fifo
// Description : Circular buffer of DEPTH {live, reg, data} entries with push,
//               pop, kill-by-register on every entry, head view, occupancy
//               count and a per-register live mask.
// Ports       : clk, rst_n (sync, active-low)
//               i_push/i_push_entry : enqueue at tail
//               i_pop               : dequeue head (caller guarantees non-empty)
//               i_kill_en/i_kill_reg: clear live on entries targeting reg
//               o_head, o_count     : head entry and occupancy 0..DEPTH
//               o_live_mask         : OR of one-hot(reg) over live entries
// Config      : REGWB_PEND_EN - when undefined, o_live_mask is tied to zero
//               and its decode is not built.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regwb_fifo
    import regwb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   i_push,
    input  wire wb_entry_t              i_push_entry,
    input  wire logic                   i_pop,
    input  wire logic                   i_kill_en,
    input  wire logic [REG_W-1:0]       i_kill_reg,
    output wb_entry_t                   o_head,
    output logic [CNT_W-1:0]            o_count,
    output logic [(1<<REG_W)-1:0]       o_live_mask
);

    wb_entry_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Kill applies to stored entries only; the arriving entry has its
            // live bit already resolved by the caller. The push below is
            // issued later so it overrides any kill on the reused tail slot.
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill_en && (r_mem[i].req.rd == i_kill_reg)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            if (i_push) begin
                r_mem[r_tail] <= i_push_entry;
                r_tail        <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

`ifdef REGWB_PEND_EN
    always_comb begin
        o_live_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].live) begin
                o_live_mask[r_mem[i].req.rd] = 1'b1;
            end
        end
    end
`else
    assign o_live_mask = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/regwb.sv
// ============================================================================
// Module      : regwb
// Description : Register-file writeback arbiter. Merges the in-order pipeline
//               (absolute priority, no backpressure) and a long-latency unit
//               (valid/ready into a DEPTH-entry queue) onto one registered
//               write port, preserving write-after-write order by killing
//               queued results that a younger pipeline write supersedes.
// Ports       : clk, rst_n (sync, active-low)
//               bus (regwb_if.slave): pipe_*, slow_*, regwrite/wrreg/wrdata,
//               pend_mask
// Config      : REGWB_PEND_EN - enables the pend_mask scoreboard; otherwise
//               pend_mask is tied to 32'h0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regwb
    import regwb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    regwb_if.slave    bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t          w_head;
    wb_entry_t          w_push_entry;
    logic [CNT_W-1:0]   w_count;
    logic [31:0]        w_live_mask;
    logic               w_slow_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_head_valid;
    logic               w_pipe_wr;

    logic               r_regwrite;
    logic [REG_W-1:0]   r_wrreg;
    logic [DATA_W-1:0]  r_wrdata;

    // Ready comes from the registered count only, so a pop this cycle does
    // not reopen the queue until the next cycle.
    assign w_slow_ready = (w_count < CNT_W'(DEPTH));
    assign w_push       = bus.slow_valid & w_slow_ready;
    assign w_head_valid = (w_count != '0);
    assign w_pipe_wr    = bus.pipe_valid & (bus.pipe_reg != ZERO_REG);

    // A dead head is discarded every cycle; a live head only pops when the
    // pipeline is silent (a pipe $zero write still claims the cycle).
    assign w_pop = w_head_valid & (~w_head.live | ~bus.pipe_valid);

    // An arriving slow result is dead if it targets $zero or if the
    // pipeline writes the same register this cycle (the pipe is younger).
    always_comb begin
        w_push_entry          = '0;
        w_push_entry.live     = (bus.slow_reg != ZERO_REG) &
                                ~(bus.pipe_valid & (bus.pipe_reg == bus.slow_reg));
        w_push_entry.req.rd   = bus.slow_reg;
        w_push_entry.req.data = bus.slow_data;
    end

    regwb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_kill_en    (bus.pipe_valid),
        .i_kill_reg   (bus.pipe_reg),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_live_mask  (w_live_mask)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regwrite <= 1'b0;
            r_wrreg    <= '0;
            r_wrdata   <= '0;
        end else if (w_pipe_wr) begin
            r_regwrite <= 1'b1;
            r_wrreg    <= bus.pipe_reg;
            r_wrdata   <= bus.pipe_data;
        end else if (w_head_valid && w_head.live && !bus.pipe_valid) begin
            r_regwrite <= 1'b1;
            r_wrreg    <= w_head.req.rd;
            r_wrdata   <= w_head.req.data;
        end else begin
            // Address and data hold their last value while idle.
            r_regwrite <= 1'b0;
        end
    end

    assign bus.slow_ready = w_slow_ready;
    assign bus.regwrite   = r_regwrite;
    assign bus.wrreg      = r_wrreg;
    assign bus.wrdata     = r_wrdata;
    assign bus.pend_mask  = w_live_mask;

endmodule

`default_nettype wire
